// File: rtl/ucode_cpu_p.sv
// Parametrised 4-phase microcoded stack CPU with bounded data/return stacks,
// fault reporting, HALT and a program-load port usable while stopped.
module ucode_cpu_p #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8,
    parameter int D_DEPTH = 12,
    parameter int R_DEPTH = 8,
    parameter int BOOT_PC = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_ld_wr,
    input  logic [ADDR_SZ-1:0] i_ld_addr,
    input  logic [DATA_SZ-1:0] i_ld_data,
    output logic               o_running,
    output logic               o_halted,
    output logic               o_status,
    output logic [2:0]         o_fault,
    output logic [ADDR_SZ-1:0] o_pc,
    output logic [DATA_SZ-1:0] o_tos
);

    localparam int DW  = $clog2(D_DEPTH + 1);
    localparam int RW  = $clog2(R_DEPTH + 1);
    localparam int PAD = DATA_SZ - ADDR_SZ - 8;
    localparam logic [ADDR_SZ-1:0] P_BOOT = ADDR_SZ'(BOOT_PC);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED, S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_ROL, OP_INC, OP_FETCH, OP_STORE,
        OP_DUP, OP_DROP, OP_SWAP, OP_SKZ, OP_TOR, OP_RFROM, OP_HALT, OP_EXIT
    } op_e;

    state_e             r_state;
    logic [ADDR_SZ-1:0] r_pc;
    logic [DATA_SZ-1:0] r_ir;
    logic [DW-1:0]      r_dsp;
    logic [RW-1:0]      r_rsp;
    logic               r_halted;
    logic               r_status;
    logic [2:0]         r_fault;
    logic [DATA_SZ-1:0] r_mem  [0:(1<<ADDR_SZ)-1];
    // Stack arrays are rounded up to a power of two so the depth counters index them directly.
    logic [DATA_SZ-1:0] r_dstk [0:(1<<DW)-1];
    logic [DATA_SZ-1:0] r_rstk [0:(1<<RW)-1];

    logic [DW-1:0]      w_dtop_i;
    logic [DW-1:0]      w_dnos_i;
    logic [RW-1:0]      w_rtop_i;
    logic [DATA_SZ-1:0] w_tos;
    logic [DATA_SZ-1:0] w_nos;
    logic [DATA_SZ-1:0] w_rtop;
    logic               w_is_call;
    logic               w_is_op;
    op_e                w_op;
    logic [ADDR_SZ-1:0] w_pc_inc;
    logic [DATA_SZ-1:0] w_ret;
    logic [ADDR_SZ-1:0] w_maddr;
    logic [ADDR_SZ-1:0] w_raddr;
    logic [DATA_SZ-1:0] w_rdata;
    logic               w_store;
    logic [1:0]         w_need;
    logic [2:0]         w_fcode;

    assign w_dtop_i  = r_dsp - DW'(1);
    assign w_dnos_i  = r_dsp - DW'(2);
    assign w_rtop_i  = r_rsp - RW'(1);
    assign w_tos     = (r_dsp == '0) ? '0 : r_dstk[w_dtop_i];
    assign w_nos     = r_dstk[w_dnos_i];
    assign w_rtop    = r_rstk[w_rtop_i];
    assign w_is_call = r_ir[7];
    assign w_is_op   = (r_ir[DATA_SZ-1:4] == '0);
    assign w_op      = op_e'(r_ir[3:0]);
    assign w_pc_inc  = r_pc + ADDR_SZ'(1);
    assign w_ret     = DATA_SZ'({w_pc_inc, 8'h80}) << PAD;
    assign w_maddr   = w_tos[DATA_SZ-1 -: ADDR_SZ];
    // One read port: EXEC serves FETCH @, every other phase reads the instruction at pc.
    assign w_raddr   = (r_state == S_EXEC) ? w_maddr : r_pc;
    assign w_rdata   = r_mem[w_raddr];
    assign w_store   = (r_state == S_EXEC) && !w_is_call && (w_op == OP_STORE);

    assign o_running = i_run && !(r_state inside {S_IDLE, S_HALTED, S_FAULT});
    assign o_halted  = r_halted;
    assign o_status  = r_status;
    assign o_fault   = r_fault;
    assign o_pc      = r_pc;
    assign o_tos     = w_tos;

    always_comb begin
        w_need  = 2'd0;
        w_fcode = 3'd0;
        case (w_op)
            OP_ADD, OP_AND, OP_XOR, OP_SWAP, OP_STORE: w_need = 2'd2;
            OP_ROL, OP_INC, OP_FETCH, OP_DUP, OP_DROP, OP_SKZ, OP_TOR: w_need = 2'd1;
            default: w_need = 2'd0;
        endcase
        if (w_is_call) begin
            if (r_rsp == RW'(R_DEPTH)) w_fcode = 3'd5;
        end else if (!w_is_op) begin
            w_fcode = 3'd1;
        end else if (32'(r_dsp) < 32'(w_need)) begin
            w_fcode = 3'd2;
        end else if ((w_op == OP_DUP || w_op == OP_RFROM) && r_dsp == DW'(D_DEPTH)) begin
            w_fcode = 3'd3;
        end else if ((w_op == OP_EXIT || w_op == OP_RFROM) && r_rsp == '0) begin
            w_fcode = 3'd4;
        end else if (w_op == OP_TOR && r_rsp == RW'(R_DEPTH)) begin
            w_fcode = 3'd5;
        end
    end

    // A STORE in flight outranks the load port; reset drops both.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_store)
                r_mem[w_maddr] <= w_nos;
            else if (i_ld_wr && !o_running)
                r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_pc     <= P_BOOT;
            r_ir     <= '0;
            r_dsp    <= '0;
            r_rsp    <= '0;
            r_halted <= 1'b0;
            r_status <= 1'b1;
            r_fault  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: if (i_run) r_state <= S_FETCH;
                S_FETCH: begin
                    if (!i_run) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ir    <= w_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_fcode != 3'd0) begin
                        r_status <= 1'b0;
                        r_fault  <= w_fcode;
                        r_state  <= S_FAULT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                    r_pc    <= w_pc_inc;
                    if (w_is_call) begin
                        r_rstk[r_rsp] <= w_ret;
                        r_rsp         <= r_rsp + RW'(1);
                        r_pc          <= r_ir[DATA_SZ-1 -: ADDR_SZ];
                    end else begin
                        case (w_op)
                            OP_ADD: begin
                                r_dstk[w_dnos_i] <= w_nos + w_tos;
                                r_dsp            <= w_dtop_i;
                            end
                            OP_AND: begin
                                r_dstk[w_dnos_i] <= w_nos & w_tos;
                                r_dsp            <= w_dtop_i;
                            end
                            OP_XOR: begin
                                r_dstk[w_dnos_i] <= w_nos ^ w_tos;
                                r_dsp            <= w_dtop_i;
                            end
                            OP_ROL:   r_dstk[w_dtop_i] <= {w_tos[DATA_SZ-2:0], w_tos[DATA_SZ-1]};
                            OP_INC:   r_dstk[w_dtop_i] <= w_tos + DATA_SZ'(1);
                            OP_FETCH: r_dstk[w_dtop_i] <= w_rdata;
                            OP_STORE: r_dsp <= w_dnos_i;
                            OP_DUP: begin
                                r_dstk[r_dsp] <= w_tos;
                                r_dsp         <= r_dsp + DW'(1);
                            end
                            OP_DROP: r_dsp <= w_dtop_i;
                            OP_SWAP: begin
                                r_dstk[w_dtop_i] <= w_nos;
                                r_dstk[w_dnos_i] <= w_tos;
                            end
                            OP_SKZ: begin
                                r_dsp <= w_dtop_i;
                                if (w_tos == '0) r_pc <= r_pc + ADDR_SZ'(2);
                            end
                            OP_TOR: begin
                                r_rstk[r_rsp] <= w_tos;
                                r_rsp         <= r_rsp + RW'(1);
                                r_dsp         <= w_dtop_i;
                            end
                            OP_RFROM: begin
                                r_dstk[r_dsp] <= w_rtop;
                                r_dsp         <= r_dsp + DW'(1);
                                r_rsp         <= w_rtop_i;
                            end
                            OP_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALTED;
                            end
                            OP_EXIT: begin
                                r_pc  <= w_rtop[DATA_SZ-1 -: ADDR_SZ];
                                r_rsp <= w_rtop_i;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WB: r_state <= S_FETCH;
                default: r_state <= r_state;
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_cpu_p.sv
// Directed self-checking bench for ucode_cpu_p: loads small programs through
// the load port, runs them and compares status outputs with hand-computed values.
module tb_ucode_cpu_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        ldWr;
    logic [7:0]  ldAddr;
    logic [15:0] ldData;
    logic        running;
    logic        halted;
    logic        status;
    logic [2:0]  fault;
    logic [7:0]  pc;
    logic [15:0] tos;

    int numChecks = 0;
    int numFails  = 0;

    ucode_cpu_p dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_run     (run),
        .i_ld_wr   (ldWr),
        .i_ld_addr (ldAddr),
        .i_ld_data (ldData),
        .o_running (running),
        .o_halted  (halted),
        .o_status  (status),
        .o_fault   (fault),
        .o_pc      (pc),
        .o_tos     (tos)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resetDut();
        run  = 1'b0;
        ldWr = 1'b0;
        rst  = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [15:0] data);
        ldAddr = addr;
        ldData = data;
        ldWr   = 1'b1;
        tick(1);
        ldWr = 1'b0;
    endtask

    task automatic runUntilStop(input string tag);
        logic done;
        done = 1'b0;
        run  = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            tick(1);
            done = halted || !status;
        end
        checkOutput({tag, "_stopped"}, 32'(done), 32'd1);
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; ldWr = 1'b0; ldAddr = '0; ldData = '0;
        tick(1);

        // Reset state
        resetDut();
        checkOutput("rst_pc", 32'(pc), 32'h0);
        checkOutput("rst_status", 32'(status), 32'd1);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_tos", 32'(tos), 32'h0);
        checkOutput("rst_running", 32'(running), 32'd0);

        // CALL 0x10 / NOP / EXIT back to 1, NOP NOP HALT; pause mid-flight
        applyStimulus(8'h00, 16'h1080);
        applyStimulus(8'h01, 16'h0000);
        applyStimulus(8'h02, 16'h0000);
        applyStimulus(8'h03, 16'h000E);
        applyStimulus(8'h10, 16'h0000);
        applyStimulus(8'h11, 16'h000F);
        run = 1'b1;
        tick(6);
        run = 1'b0;
        tick(8);
        checkOutput("pause_running", 32'(running), 32'd0);
        checkOutput("pause_pc", 32'(pc), 32'h11);
        checkOutput("pause_halted", 32'(halted), 32'd0);
        runUntilStop("call");
        checkOutput("call_halted", 32'(halted), 32'd1);
        checkOutput("call_status", 32'(status), 32'd1);
        checkOutput("call_pc", 32'(pc), 32'h04);
        tick(5);
        checkOutput("call_pc_held", 32'(pc), 32'h04);

        // Build 0x4000 from two CALL return words, FETCH 0xFFFF, INC wraps to 0
        resetDut();
        applyStimulus(8'h00, 16'h0F80);
        applyStimulus(8'h0F, 16'h2080);
        applyStimulus(8'h20, 16'h000D);
        applyStimulus(8'h21, 16'h4F80);
        applyStimulus(8'h4F, 16'h6080);
        applyStimulus(8'h60, 16'h000D);
        applyStimulus(8'h61, 16'h0003);
        applyStimulus(8'h62, 16'h0006);
        applyStimulus(8'h63, 16'h0005);
        applyStimulus(8'h64, 16'h000E);
        applyStimulus(8'h40, 16'hFFFF);
        runUntilStop("inc");
        checkOutput("inc_wrap_tos", 32'(tos), 32'h0000);
        checkOutput("inc_pc", 32'(pc), 32'h65);
        checkOutput("inc_status", 32'(status), 32'd1);

        resetDut();
        applyStimulus(8'h40, 16'h8001);
        applyStimulus(8'h63, 16'h0004);
        runUntilStop("rol");
        checkOutput("rol_tos", 32'(tos), 32'h0003);

        // D underflow, then stuck in FAULT
        resetDut();
        applyStimulus(8'h00, 16'h0009);
        runUntilStop("uflow");
        checkOutput("uflow_fault", 32'(fault), 32'd2);
        checkOutput("uflow_status", 32'(status), 32'd0);
        checkOutput("uflow_pc", 32'(pc), 32'h00);
        run = 1'b1;
        tick(10);
        checkOutput("uflow_held_pc", 32'(pc), 32'h00);
        checkOutput("uflow_held_fault", 32'(fault), 32'd2);
        checkOutput("uflow_running", 32'(running), 32'd0);
        run = 1'b0;

        // D overflow: 11 DUPs fill 12 cells, next DUP faults
        resetDut();
        applyStimulus(8'h00, 16'h2080);
        applyStimulus(8'h20, 16'h000D);
        for (int a = 8'h21; a <= 8'h2C; a++) applyStimulus(8'(a), 16'h0008);
        runUntilStop("doflow");
        checkOutput("doflow_fault", 32'(fault), 32'd3);
        checkOutput("doflow_pc", 32'(pc), 32'h2C);
        checkOutput("doflow_tos", 32'(tos), 32'h0180);

        // R overflow through self-recursive CALL
        resetDut();
        applyStimulus(8'h00, 16'h3080);
        applyStimulus(8'h30, 16'h3080);
        runUntilStop("roflow");
        checkOutput("roflow_fault", 32'(fault), 32'd5);
        checkOutput("roflow_pc", 32'(pc), 32'h30);

        // Illegal word faults on the DECODE edge
        resetDut();
        applyStimulus(8'h00, 16'h0070);
        run = 1'b1;
        tick(2);
        checkOutput("illegal_pre_status", 32'(status), 32'd1);
        tick(1);
        checkOutput("illegal_fault", 32'(fault), 32'd1);
        checkOutput("illegal_pc", 32'(pc), 32'h00);
        run = 1'b0;

        // Reset during EXEC of STORE leaves memory alone
        resetDut();
        applyStimulus(8'h00, 16'h2080);
        applyStimulus(8'h01, 16'h1234);
        applyStimulus(8'h20, 16'h000D);
        applyStimulus(8'h21, 16'h0008);
        applyStimulus(8'h22, 16'h0007);
        applyStimulus(8'h23, 16'h000E);
        run = 1'b1;
        tick(15);
        checkOutput("store_exec_pc", 32'(pc), 32'h22);
        rst = 1'b1;
        run = 1'b0;
        tick(1);
        rst = 1'b0;
        checkOutput("midrst_pc", 32'(pc), 32'h00);
        checkOutput("midrst_running", 32'(running), 32'd0);
        checkOutput("midrst_tos", 32'(tos), 32'h0);
        applyStimulus(8'h21, 16'h0006);
        applyStimulus(8'h22, 16'h000E);
        runUntilStop("midrst_rd");
        checkOutput("midrst_mem", 32'(tos), 32'h1234);

        // Completed STORE, read back next run
        resetDut();
        applyStimulus(8'h21, 16'h0008);
        applyStimulus(8'h22, 16'h0007);
        applyStimulus(8'h23, 16'h000E);
        runUntilStop("store");
        checkOutput("store_tos_empty", 32'(tos), 32'h0);
        resetDut();
        applyStimulus(8'h21, 16'h0006);
        applyStimulus(8'h22, 16'h000E);
        runUntilStop("store_rd");
        checkOutput("store_mem", 32'(tos), 32'h0180);

        // Load strobe while running is ignored
        resetDut();
        run = 1'b1;
        tick(2);
        checkOutput("ldrun_running", 32'(running), 32'd1);
        applyStimulus(8'h01, 16'hBEEF);
        runUntilStop("ldrun");
        checkOutput("ldrun_mem", 32'(tos), 32'h0180);

        // SKZ on zero at 0xFF wraps to 0x01
        resetDut();
        applyStimulus(8'h00, 16'hFC80);
        applyStimulus(8'hFC, 16'h000D);
        applyStimulus(8'hFD, 16'h0008);
        applyStimulus(8'hFE, 16'h0003);
        applyStimulus(8'hFF, 16'h000B);
        applyStimulus(8'h01, 16'h000E);
        runUntilStop("skz");
        checkOutput("skz_halted", 32'(halted), 32'd1);
        checkOutput("skz_pc", 32'(pc), 32'h02);
        checkOutput("skz_tos", 32'(tos), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
